// File: rtl/mux8to1_if.sv
// mux8to1_if: bus bundle for the 8:1 selector.
// in/sel from the master, out/out_q/sel_q/rise/fall/toggle_cnt back.
interface mux8to1_if #(
  parameter int COUNT_W = 8
);
  logic [7:0]         in;
  logic [2:0]         sel;
  logic               out;
  logic               out_q;
  logic [2:0]         sel_q;
  logic               rise;
  logic               fall;
  logic [COUNT_W-1:0] toggle_cnt;

  modport master (
    output in, sel,
    input  out, out_q, sel_q,
    input  rise, fall, toggle_cnt
  );

  modport slave (
    input  in, sel,
    output out, out_q, sel_q,
    output rise, fall, toggle_cnt
  );
endinterface

// File: rtl/mux8to1.sv
// mux8to1: combinational in[sel] plus a registered view with
// edge pulses and a saturating edge count. Ports: clk, rst_n, bus.
module mux8to1 #(
  parameter int COUNT_W = 8
) (
  input logic     clk,
  input logic     rst_n,
  mux8to1_if.slave bus
);

  logic               q_d;
  logic               chg;
  logic [COUNT_W-1:0] cnt;

  assign bus.out        = bus.in[bus.sel];
  assign bus.toggle_cnt = cnt;

  // q_d holds the previous out_q, so pulses land one
  // cycle after out_q itself changes.
  assign chg = bus.out_q ^ q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_q <= 1'b0;
      bus.sel_q <= 3'd0;
      q_d       <= 1'b0;
      bus.rise  <= 1'b0;
      bus.fall  <= 1'b0;
      cnt       <= '0;
    end else begin
      bus.out_q <= bus.in[bus.sel];
      bus.sel_q <= bus.sel;
      q_d       <= bus.out_q;
      bus.rise  <= bus.out_q & ~q_d;
      bus.fall  <= ~bus.out_q & q_d;
      if (chg && (cnt != {COUNT_W{1'b1}}))
        cnt <= cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux8to1.sv
// tb_mux8to1: directed checks of mux8to1, default width
// and a 2-bit counter instance sharing clk/rst_n.
module tb_mux8to1;

  logic clk;
  logic rst_n;
  logic run;
  int   checks;
  int   errors;

  mux8to1_if #(.COUNT_W(8)) bus ();
  mux8to1_if #(.COUNT_W(2)) bus2 ();

  mux8to1 #(.COUNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mux8to1 #(.COUNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (run) clk = ~clk;
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [2:0] s);
    bus.in   = d;
    bus.sel  = s;
    bus2.in  = d;
    bus2.sel = s;
  endtask

  task automatic edge_wait;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    run    = 1'b0;
    rst_n  = 1'b1;
    drive(8'b1010_1010, 3'd0);

    // combinational path, no clock at all
    for (int i = 0; i < 8; i++) begin
      drive(8'b1010_1010, 3'(i));
      #50;
      check($sformatf("out_sel%0d", i), 32'(bus.out), 32'(i % 2));
      #50;
    end

    // asynchronous reset, still no clock
    drive(8'hFF, 3'd5);
    rst_n = 1'b0;
    #10;
    check("rst_out", 32'(bus.out), 32'd1);
    check("rst_out_q", 32'(bus.out_q), 32'd0);
    check("rst_sel_q", 32'(bus.sel_q), 32'd0);
    check("rst_rise", 32'(bus.rise), 32'd0);
    check("rst_fall", 32'(bus.fall), 32'd0);
    check("rst_cnt", 32'(bus.toggle_cnt), 32'd0);
    check("rst_cnt2", 32'(bus2.toggle_cnt), 32'd0);

    // release, first sampled bit is 1
    drive(8'hAA, 3'd1);
    #3;
    rst_n = 1'b1;
    run   = 1'b1;
    edge_wait();
    check("e1_out_q", 32'(bus.out_q), 32'd1);
    check("e1_sel_q", 32'(bus.sel_q), 32'd1);
    check("e1_rise", 32'(bus.rise), 32'd0);
    check("e1_cnt", 32'(bus.toggle_cnt), 32'd0);
    edge_wait();
    check("e2_rise", 32'(bus.rise), 32'd1);
    check("e2_fall", 32'(bus.fall), 32'd0);
    check("e2_cnt", 32'(bus.toggle_cnt), 32'd1);
    edge_wait();
    check("e3_rise", 32'(bus.rise), 32'd0);
    check("e3_cnt", 32'(bus.toggle_cnt), 32'd1);

    // sel alternates 2/1 each cycle: out_q toggles every cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(8'hAA, (i % 2 == 0) ? 3'd2 : 3'd1);
      edge_wait();
      check($sformatf("alt%0d_out_q", i), 32'(bus.out_q), 32'(i % 2));
      check($sformatf("alt%0d_sel_q", i), 32'(bus.sel_q),
            (i % 2 == 0) ? 32'd2 : 32'd1);
      check($sformatf("alt%0d_fall", i), 32'(bus.fall),
            32'((i >= 1) && ((i - 1) % 2 == 0)));
      check($sformatf("alt%0d_rise", i), 32'(bus.rise),
            32'((i >= 1) && ((i - 1) % 2 == 1)));
      check($sformatf("alt%0d_cnt", i), 32'(bus.toggle_cnt), 32'(1 + i));
      check($sformatf("alt%0d_cnt2", i), 32'(bus2.toggle_cnt),
            (1 + i > 3) ? 32'd3 : 32'(1 + i));
    end

    // last transition (0->1) pulses on the following edge
    edge_wait();
    check("tail_rise", 32'(bus.rise), 32'd1);
    check("tail_cnt", 32'(bus.toggle_cnt), 32'd11);
    check("tail_cnt2", 32'(bus2.toggle_cnt), 32'd3);

    // reset between edges cuts the pulse at once
    #1;
    rst_n = 1'b0;
    #1;
    check("cut_rise", 32'(bus.rise), 32'd0);
    check("cut_cnt", 32'(bus.toggle_cnt), 32'd0);
    check("cut_out_q", 32'(bus.out_q), 32'd0);
    check("cut_cnt2", 32'(bus2.toggle_cnt), 32'd0);
    check("cut_out", 32'(bus.out), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
